// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between the per-CPU icache request lines, the
// responder and the shared RAM read port.
interface imem_responder_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]        iREN;      // per-CPU read request
  logic [CPUS-1:0][31:0]  iaddr;     // per-CPU word address
  logic [CPUS-1:0]        iwait;     // per-CPU stall
  logic [CPUS-1:0][31:0]  iload;     // per-CPU returned word
  logic                   ramREN;    // RAM read enable
  logic [31:0]            ramaddr;   // RAM address
  logic [31:0]            ramload;   // RAM read data
  logic [1:0]             ramstate;  // FREE / BUSY / ACCESS / ERROR
  logic                   rerr;      // read-error pulse

  // Responder side.
  modport slave (
    input  iREN, iaddr, ramload, ramstate,
    output iwait, iload, ramREN, ramaddr, rerr
  );

  // Requester / RAM side.
  modport master (
    output iREN, iaddr, ramload, ramstate,
    input  iwait, iload, ramREN, ramaddr, rerr
  );
endinterface

// File: rtl/imem_responder.sv
// Memory-side responder for the instruction-fetch request/wait/load
// protocol: round-robin arbitration among CPUS requesters, one read at a
// time to the shared RAM, and iwait held high until each word returns.
module imem_responder #(
  parameter int          CPUS    = 2,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input logic             CLK,
  input logic             RST,
  imem_responder_if.slave bus
);

  localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef logic [OW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  idx_t        owner;      // CPU currently granted
  idx_t        last;       // CPU most recently served
  idx_t        grant;      // round-robin winner this cycle
  logic        grant_vld;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic        rerr_r;

  // Candidate CPU 'step' positions after 'base', wrapping at CPUS.
  function automatic idx_t rr_idx(input idx_t base, input int step);
    return idx_t'((int'(base) + step) % CPUS);
  endfunction

  // Round-robin scan starting just after the last served CPU.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 1; i <= CPUS; i++) begin
      if (!grant_vld && bus.iREN[rr_idx(last, i)]) begin
        grant_vld = 1'b1;
        grant     = rr_idx(last, i);
      end
    end
  end

  // FSM state register; reset also drops ramREN asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and combinational bus outputs.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt   = state;
    bus.ramREN  = 1'b0;
    bus.ramaddr = '0;
    bus.iwait   = '0;
    bus.iload   = '0;

    case (state)
      IDLE: if (grant_vld) state_nxt = READ;
      READ: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = addr_r;
        // Requester abort wins over any RAM completion this cycle.
        if (!bus.iREN[owner])
          state_nxt = IDLE;
        else if (bus.ramstate == RAM_ACCESS || bus.ramstate == RAM_ERROR)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    for (int k = 0; k < CPUS; k++) begin
      bus.iwait[k] = bus.iREN[k] && !(state == RESP && owner == idx_t'(k));
      bus.iload[k] = (owner == idx_t'(k)) ? data_r : '0;
    end
  end

  // Grant, address/data capture, round-robin pointer and error pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner  <= '0;
      last   <= idx_t'(CPUS - 1);  // CPU0 wins the first scan
      addr_r <= '0;
      data_r <= '0;
      rerr_r <= 1'b0;
    end else begin
      rerr_r <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner  <= grant;
            addr_r <= bus.iaddr[grant];
          end
        end
        READ: begin
          // An aborted read leaves data_r and last untouched.
          if (bus.iREN[owner]) begin
            if (bus.ramstate == RAM_ACCESS) begin
              data_r <= bus.ramload;
            end else if (bus.ramstate == RAM_ERROR) begin
              data_r <= ERRWORD;
              rerr_r <= 1'b1;
            end
          end
        end
        RESP:    last <= owner;
        default: ;
      endcase
    end
  end

  assign bus.rerr = rerr_r;

endmodule
